// File: rtl/data_mem_lsu.sv
// data_mem_lsu: word-organised data memory behind a RISC-V load/store unit.
//
// Accepts one load or store per cycle. The effective address is rs1 + Immediate.
// Stores write only their enabled byte lanes. Loads are read at the accepting
// edge and returned one cycle later, sign- or zero-extended as funct3 asks.
// A misaligned access or an illegal funct3 leaves the array untouched and
// returns err. After reset the array can be cleared word by word. No request
// is accepted while that clear is running.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  request present this cycle
//   req_ready  request accepted this cycle (low while clearing)
//   req_we     1 = store, 0 = load
//   funct3     RISC-V load/store size/sign field
//   rs1        base address
//   Immediate  address offset
//   wdata      store data (byte/half taken from the low bits)
//   rdata      load result, held while rvalid is low
//   rvalid     one-cycle response pulse for the previous accepted request
//   err        qualified by rvalid: misaligned or illegal funct3
//   busy       clear sequence in progress
module data_mem_lsu #(
    parameter int unsigned DEPTH          = 256,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] Immediate,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        err,
    output logic        busy
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {S_INIT, S_READY} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, err_q;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   ea;
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic          accept, illegal, misal, fault, do_store;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic          unused_ea_hi;

    function automatic logic [31:0] load_ext(input logic [31:0] word,
                                             input logic [1:0]  ln,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ln, 3'b000} +: 8];
        h = ln[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   load_ext = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   load_ext = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_ext = word;
        endcase
    endfunction

    // Address bits above the array size are ignored, so addresses wrap.
    assign ea           = rs1 + Immediate;
    assign widx         = ea[AW+1:2];
    assign lane         = ea[1:0];
    assign unused_ea_hi = ^ea[31:AW+2];

    assign accept = req_valid & req_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_INIT: begin
                busy  = 1'b1;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_READY;
                end
            end
            default: begin
                req_ready = 1'b1;
            end
        endcase
    end

    always_comb begin
        if (req_we) begin
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        misal = ((funct3[1:0] == 2'b01) && ea[0]) ||
                ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
        fault = illegal | misal;

        // Store data is replicated across lanes; the byte enables pick the lanes written.
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wlane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = ea[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata;
            end
        endcase

        do_store = accept & req_we & ~fault;

        rdata_d = rdata_q;
        if (accept) begin
            rdata_d = (fault || req_we) ? 32'h0 : load_ext(mem[widx], lane, funct3);
        end
    end

    // The clear sequencer and stores share the single write port.
    // Clearing starts one edge after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT) begin
                mem[cnt_q] <= '0;
            end else if (do_store) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[widx][8*b +: 8] <= wlane[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= (CLEAR_ON_RESET != 0) ? S_INIT : S_READY;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= accept;
            err_q    <= accept & fault;
            rdata_q  <= rdata_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Parametrised successor to the core's single-cycle data RAM.
- Word-organised data memory with RISC-V byte, half and word load/store semantics, byte enables and sign/zero extension.
- Registered 1-cycle load latency with a valid handshake, plus misalignment and illegal-funct3 detection.
- Clears its array with a multi-cycle init sequencer after reset; sits between the execute stage (rs1 + Immediate) and write-back.

Parameters:
- DEPTH, 256, number of 32-bit words; power of 2, 2..4096.
- AW, $clog2(DEPTH), word-index width (derived; not overridden).
- CLEAR_ON_RESET, 1, when 1 the array is zeroed after reset; when 0 init is skipped.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present this cycle.
- req_ready  output  1  block accepts a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- funct3  input  3  access size/sign: RISC-V load/store funct3.
- rs1  input  32  base address.
- Immediate  input  32  offset; effective address ea = rs1 + Immediate (mod 2^32).
- wdata  input  32  store data; byte/half taken from the low bits.
- rdata  output  32  load result, extended per funct3.
- rvalid  output  1  1-cycle pulse: response for the request accepted on the previous edge (loads and stores).
- err  output  1  qualified by rvalid: misaligned or illegal funct3.
- busy  output  1  init sequence in progress.

Behaviour:
- Reset (rst = 1 at a rising edge): state = INIT if CLEAR_ON_RESET, else READY.
- Reset values: rdata = 0, rvalid = 0, err = 0, busy = CLEAR_ON_RESET, init counter = 0. Any in-flight response is discarded.
- States:
  - INIT: req_ready = 0, busy = 1. Writes 0 to word[cnt] each cycle, cnt++. After writing word DEPTH-1, goes to READY.
  - READY: req_ready = 1, busy = 0. No other states.
- INIT takes exactly DEPTH cycles. req_ready rises on the cycle after the last clear write.
- Requests in INIT are ignored; no rvalid is generated.
- Accept: req_valid & req_ready at the rising edge.
- Word index = ea[AW+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- Byte lane = ea[1:0].
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Misaligned: half with ea[0] = 1; word with ea[1:0] != 0.
- Faulting request (misaligned or illegal funct3): no array write. Next cycle rvalid = 1, err = 1, rdata = 0.
- Store: on the accepting edge, write only the enabled bytes.
  - SB: byte wdata[7:0] to lane ea[1:0].
  - SH: wdata[15:0] to lanes {ea[1],0} and {ea[1],1}.
  - SW: all 4 lanes.
  - Next cycle: rvalid = 1, err = 0, rdata = 0.
- Load: the array is read at the accepting edge. Next cycle: rvalid = 1, err = 0, rdata = selected lane(s).
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: full word.
- Throughput: 1 request per cycle, back-to-back.
- Store-then-load to the same word on consecutive cycles: the load returns the new data (the write completes at the earlier edge).
- rvalid = 0 on any cycle following an edge with no accept. rdata holds its last value when rvalid = 0.
- rst asserted mid-INIT or mid-traffic: the next edge applies reset values and restarts INIT from word 0. Array contents are only guaranteed zero once INIT completes.
- Little-endian byte order throughout.

Test Plan:
- Reset, DEPTH=16: assert rst 1 cycle → busy = 1 for exactly 16 cycles, then req_ready = 1. LW from ea = 0x3C returns rdata = 0x00000000, err = 0.
- SW wdata = 0x80FF_7F01 at rs1 = 0x10, Immediate = 0x4, then back-to-back:
  - LB ea = 0x14 → 0x00000001.
  - LB ea = 0x17 → 0xFFFFFF80.
  - LBU ea = 0x17 → 0x00000080.
  - LH ea = 0x16 → 0xFFFF80FF.
  - LHU ea = 0x16 → 0x000080FF.
  - Each result appears exactly 1 cycle after its accept.
- SB 0xAA at ea = 0x15 over the word above → LW ea = 0x14 returns 0x80FFAA01 (other bytes untouched).
- Misaligned and illegal accesses → rvalid = 1, err = 1, rdata = 0, memory unchanged (confirmed by a following LW):
  - LW ea = 0x22.
  - SH ea = 0x21.
  - funct3 = 011.
- Wrap, DEPTH=16: SW 0x12345678 at ea = 0x40 → LW ea = 0x00 returns 0x12345678. Negative Immediate = 0xFFFFFFFC with rs1 = 0x44 hits the same word.
- Assert rst mid-INIT (cycle 5) and again after writes → INIT restarts, full DEPTH cycles, no rvalid during INIT, prior data reads back 0.
